esm_instr_window: RTL
=====================

# esm_instr_window

Parametrised circular instruction window for the ESM datapath, succeeding the free-running instruction buffer. Instructions enter through a valid/ready push port, are held in a DEPTH-entry ring with a per-entry valid bitmap, and leave in order through a valid/ready pop port. The block adds occupancy tracking, full/empty back-pressure, optional NOP (all-zero word) filtering, a synchronous flush and a random-access lookup port for ESM_Core's dependency checks.

## Interface

Parameters:
- IW, 32, instruction word width in bits.
- DEPTH, 16, number of entries; power of two, ≥ 2.
- DROP_NOP, 1, when 1 an accepted all-zero word is consumed but not stored.
- AW, $clog2(DEPTH), index width (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all entries.
- in_valid  in  1  push request.
- in_instr  in  IW  word to push.
- in_ready  out  1  window can accept; equals !full.
- out_valid  out  1  head entry available; equals !empty.
- out_ready  in  1  consumer takes head.
- out_instr  out  IW  head instruction (combinational from storage).
- out_index  out  AW  slot index of head (read pointer).
- rd_index  in  AW  lookup slot.
- rd_instr  out  IW  instruction stored at rd_index.
- rd_valid  out  1  valid_map[rd_index].
- valid_map  out  DEPTH  per-slot valid bits, bit i = slot i.
- count  out  AW+1  occupied entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation

- State: wr_ptr (AW), rd_ptr (AW), count (AW+1), valid_map (DEPTH), storage array DEPTH×IW.
- Push fires when in_valid && in_ready. If DROP_NOP=1 and in_instr == 0: handshake completes, no storage/pointer/count/valid change. Otherwise mem[wr_ptr] <= in_instr, valid_map[wr_ptr] <= 1, wr_ptr increments.
- Pop fires when out_valid && out_ready: valid_map[rd_ptr] <= 0, rd_ptr increments. Stored word is not cleared.
- Pointers wrap DEPTH-1 → 0 by natural AW-bit overflow.
- count: +1 on storing push only, −1 on pop only, unchanged when both or neither.
- Simultaneous push and pop on same slot impossible: push requires !full, pop requires !empty; when neither limit is hit, both proceed in the same cycle.
- Full: in_ready = 0 even if a pop fires that cycle (no pass-through of space).
- Empty: out_valid = 0; no bypass of in_instr to out_instr.
- Flush: wr_ptr, rd_ptr, count, valid_map cleared to 0; takes priority over push and pop in the same cycle (neither takes effect, although in_ready/out_valid may have been high). Storage contents are left unchanged.
- rd port is purely combinational, independent of handshakes; rd_instr reflects array contents regardless of rd_valid.

## Timing

- Reset (async assert, deassert synchronous to clk): wr_ptr=0, rd_ptr=0, count=0, valid_map=0 ⇒ empty=1, full=0, in_ready=1, out_valid=0, out_index=0, rd_valid=0. Storage not reset; out_instr/rd_instr undefined until written.
- Reset mid-operation clears all state immediately, in-flight handshakes lost.
- Push-to-pop latency: a word pushed at edge N is visible on out_instr with out_valid=1 after edge N (1 cycle).
- Pop takes effect at the edge; next head visible combinationally after it.
- All status outputs (full, empty, count, valid_map, in_ready, out_valid) are registered-state decodes, update only on clk edges or rst.

## Test plan

- Reset then push 0xA, 0xB, 0xC one per cycle with out_ready=0 -> count=3, valid_map=0x0007, out_instr=0xA, out_index=0.
- Fill to DEPTH=16 (words 1..16), hold in_valid=1 -> full=1, in_ready=0, 17th word not stored; then pop all 16 -> sequence 1..16 in order, empty=1.
- Steady push+pop each cycle for 40 cycles -> count constant, pointers wrap past 15→0, output order equals input order.
- DROP_NOP=1, push 0x5, 0x0, 0x6 -> count=2, pop order 0x5, 0x6; DROP_NOP=0 same stimulus -> count=3, 0x0 popped second.
- Push 5 words, assert flush with in_valid=1 and out_ready=1 same cycle -> next cycle count=0, valid_map=0, empty=1, nothing popped or stored.
- Push 4 words, pop 1, set rd_index=0 then 2 -> rd_valid=0 with rd_instr=word0, then rd_valid=1 with rd_instr=word2; assert rst asynchronously mid-stream -> outputs return to reset values before next edge.

Source files
------------

// File: rtl/esm_instr_window.sv
// Circular instruction window: DEPTH-entry ring with per-slot valid bitmap,
// in-order valid/ready push/pop, optional NOP dropping, flush and lookup port.
module esm_instr_window #(
    parameter int IW       = 32,
    parameter int DEPTH    = 16,
    parameter int DROP_NOP = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [IW-1:0]    in_instr,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW-1:0]    out_instr,
    output logic [AW-1:0]    out_index,
    input  logic [AW-1:0]    rd_index,
    output logic [IW-1:0]    rd_instr,
    output logic             rd_valid,
    output logic [DEPTH-1:0] valid_map,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [DEPTH-1:0] valid_map_q, valid_map_d;
    logic [IW-1:0]    mem [DEPTH];

    logic push_fire, pop_fire, is_nop, store;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push_fire = in_valid && in_ready;
    assign pop_fire  = out_valid && out_ready;
    // A dropped NOP still completes the handshake, it just never lands in the ring.
    assign is_nop    = (DROP_NOP != 0) && (in_instr == '0);
    assign store     = push_fire && !is_nop;

    assign out_instr = mem[rd_ptr_q];
    assign out_index = rd_ptr_q;
    assign rd_instr  = mem[rd_index];
    assign rd_valid  = valid_map_q[rd_index];
    assign valid_map = valid_map_q;
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (store)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_fire)
            rd_ptr_d = rd_ptr_q + 1'b1;
        if (store && !pop_fire)
            count_d = count_q + 1'b1;
        else if (!store && pop_fire)
            count_d = count_q - 1'b1;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Push and pop never target the same slot, so each bit needs one rule only.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            always_comb begin
                valid_map_d[gi] = valid_map_q[gi];
                if (flush)
                    valid_map_d[gi] = 1'b0;
                else if (store && (wr_ptr_q == AW'(gi)))
                    valid_map_d[gi] = 1'b1;
                else if (pop_fire && (rd_ptr_q == AW'(gi)))
                    valid_map_d[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            valid_map_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            valid_map_q <= valid_map_d;
        end
    end

    // Storage is never reset or cleared; only storing pushes write it.
    always_ff @(posedge clk) begin
        if (store && !flush)
            mem[wr_ptr_q] <= in_instr;
    end

endmodule
